// File: rtl/counter_pkg.sv
// counter_pkg: shared types and defaults for the counter and its checker
package counter_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;
    localparam int CNT_W  = 4;
    localparam int GOOD_W = 4;
endpackage

// File: rtl/counter_checker_sat_counter.sv
// sat_counter: up-counter with synchronous clear that sticks at all-ones
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    logic [W-1:0] r_q;
    always_ff @(posedge clk) begin
        if (clr)
            r_q <= '0;
        else if (inc && r_q != {W{1'b1}})
            r_q <= r_q + W'(1);
    end
    assign q = r_q;
endmodule

// File: rtl/counter_checker.sv
// counter_checker: passive monitor that locks onto a +1 counter sequence
// and reports mismatches and wraps one edge after each valid sample
module counter_checker
    import counter_pkg::*;
#(
    parameter int WIDTH      = CNT_W,
    parameter int LOCK_COUNT = 2,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [WIDTH-1:0] count_in,
    output logic             locked,
    output logic             err_pulse,
    output logic             wrap_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] expected
);
    state_t r_state, w_state_nxt;
    logic [WIDTH-1:0]  r_exp, w_exp_nxt;
    logic [GOOD_W-1:0] r_good, w_good_nxt, w_good_inc;
    logic r_err_pulse, r_wrap_pulse, w_err, w_wrap, w_match;
    assign w_match    = count_in == r_exp;
    assign w_good_inc = r_good + GOOD_W'(1);
    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        w_exp_nxt   = r_exp;
        w_err       = 1'b0;
        w_wrap      = 1'b0;
        if (valid) begin
            w_exp_nxt = count_in + WIDTH'(1);
            case (r_state)
                IDLE: begin
                    w_state_nxt = ACQUIRE;
                    w_good_nxt  = '0;
                end
                ACQUIRE: begin
                    w_good_nxt = w_match ? w_good_inc : '0;
                    if (w_match && w_good_inc == GOOD_W'(LOCK_COUNT)) begin
                        w_state_nxt = LOCKED;
                        w_good_nxt  = '0;
                    end
                end
                LOCKED: begin
                    w_wrap = w_match && count_in == '0;
                    w_err  = !w_match;
                    if (!w_match) begin
                        w_state_nxt = ACQUIRE;
                        w_good_nxt  = '0;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_exp        <= '0;
            r_good       <= '0;
            r_err_pulse  <= 1'b0;
            r_wrap_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_exp        <= w_exp_nxt;
            r_good       <= w_good_nxt;
            r_err_pulse  <= w_err;
            r_wrap_pulse <= w_wrap;
        end
    end
    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk (clk),
        .clr (rst),
        .inc (w_err),
        .q   (err_count)
    );
    assign locked     = r_state == LOCKED;
    assign err_pulse  = r_err_pulse;
    assign wrap_pulse = r_wrap_pulse;
    assign expected   = r_exp;
endmodule
